spy_fifo: RTL

SPY_FIFO -- requirements
Module: spy_fifo

---
 rtl/spy_fifo.sv | 104 ++++++++++
 1 files changed

// File: rtl/spy_fifo.sv
// First-word fall-through FIFO with occupancy/threshold flags and optional error counters.
// Define SPY_FIFO_ERR_EN to build the sticky overflow flag and saturating drop counter.
module spy_fifo #(
    parameter int DATA_WIDTH    = 64,
    parameter int FIFO_DEPTH    = 32,
    parameter int AFULL_THRESH  = FIFO_DEPTH - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            push_valid_i,
    input  logic [DATA_WIDTH-1:0]           push_data_i,
    output logic                            push_ready_o,
    output logic                            pop_valid_o,
    output logic [DATA_WIDTH-1:0]           pop_data_o,
    input  logic                            pop_ready_i,
    input  logic                            flush_i,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] count_o,
    output logic                            almost_full_o,
    output logic                            almost_empty_o,
    output logic                            overflow_o,
    output logic [15:0]                     drop_cnt_o,
    input  logic                            clr_err_i
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST_IDX = PW'(FIFO_DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  push_acc;
    logic                  pop_acc;

    // Handshake flags come only from registered occupancy, never from the peer's valid/ready.
    assign push_ready_o   = (count_o != CW'(FIFO_DEPTH));
    assign pop_valid_o    = (count_o != '0);
    assign almost_full_o  = (count_o >= CW'(AFULL_THRESH));
    assign almost_empty_o = (count_o <= CW'(AEMPTY_THRESH));

    assign push_acc = push_valid_i && push_ready_o && !flush_i;
    assign pop_acc  = pop_valid_o && pop_ready_i && !flush_i;

    assign pop_data_o = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_acc)
            mem[wr_ptr] <= push_data_i;
    end

    // Explicit wrap keeps the pointers correct for non-power-of-two depths.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else if (flush_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else begin
            if (push_acc)
                wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
            if (pop_acc)
                rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + 1'b1;
            case ({push_acc, pop_acc})
                2'b10:   count_o <= count_o + 1'b1;
                2'b01:   count_o <= count_o - 1'b1;
                default: count_o <= count_o;
            endcase
        end
    end

`ifdef SPY_FIFO_ERR_EN
    logic ovf_event;

    assign ovf_event = push_valid_i && !push_ready_o && !flush_i;

    // A new overflow in the same cycle as a clear restarts the count at one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
        end else if (ovf_event) begin
            overflow_o <= 1'b1;
            if (clr_err_i)
                drop_cnt_o <= 16'd1;
            else if (drop_cnt_o != 16'hFFFF)
                drop_cnt_o <= drop_cnt_o + 16'd1;
        end else if (clr_err_i) begin
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
        end
    end
`else
    logic unused_clr_err;

    assign unused_clr_err = clr_err_i;
    assign overflow_o     = 1'b0;
    assign drop_cnt_o     = '0;
`endif

endmodule
